// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants and FSM encoding for the memory-mapped UART receiver
//   Register word offsets, STATUS/CTRL bit positions and receiver state type.
package uart_rx_pkg;

  // Register word offsets from BASE_ADDR
  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_POP    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAMING   = 3;
  localparam int ST_PARITY    = 4;
  localparam int ST_COUNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_RX_EN   = 0;
  localparam int CTRL_CLR_ERR = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8-bit synchronous FIFO holding received bytes
//   Ports: clk, rst_n (async active-low), i_push/i_data write side,
//   i_pop read side, o_data (head), o_full, o_empty, o_count (FIFO_AW+1 bits).
//   A pop on empty is ignored; a push on full is accepted only when a pop
//   happens in the same cycle.
module uart_rx_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [7:0]       i_data,
  input  logic             i_pop,
  output logic [7:0]       o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [FIFO_AW:0] o_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == DEPTH_C);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_mm.sv
// rtl/uart_rx_mm.sv - memory-mapped 8N1 UART receiver with byte FIFO and level IRQ
//   Ports: clk, rst (async active-low), RxD (async serial in, idle high),
//   inputData/inputAddr/wrEn (CPU write), outputAddr/outputData (comb read),
//   irq (registered rxEn & FIFO not empty).
//   Registers at BASE_ADDR+0..3: RXDATA, STATUS, POP, CTRL.
//   Define UART_RX_PARITY_EN for 8E1 frames with a parity check state.
module uart_rx_mm
  import uart_rx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_AW      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RxD,
  input  logic [31:0] inputData,
  input  logic [31:0] inputAddr,
  input  logic        wrEn,
  input  logic [31:0] outputAddr,
  output logic [31:0] outputData,
  output logic        irq
);

  localparam logic [15:0] CNT_FULL = 16'(CLKS_PER_BIT);
  localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2);

  logic             r_rx_s1, r_rx_s2;
  logic             w_rx;
  rx_state_t        r_state, w_state_nxt;
  logic [15:0]      r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_expire;
  logic             w_push, w_frm_set;
  logic             r_rx_en, r_overrun, r_frm_err, r_irq;
  logic [31:0]      w_wr_off, w_rd_off;
  logic             w_wr_hit, w_pop_req, w_ctrl_wr, w_clr, w_ovr_set;
  logic [7:0]       w_head;
  logic             w_full, w_empty;
  logic [FIFO_AW:0] w_count;
  logic [31:0]      w_status;
  logic             w_unused;
`ifdef UART_RX_PARITY_EN
  logic             r_par_bad, w_par_bad_nxt;
  logic             w_par_set;
  logic             r_par_err;
`endif

  assign w_rx     = r_rx_s2;
  assign w_expire = (r_cnt == 16'd1);
  assign w_unused = ^inputData[31:2];

  // Write decode: only the low two offset bits select a register once in range.
  assign w_wr_off  = inputAddr - BASE_ADDR;
  assign w_wr_hit  = wrEn & (w_wr_off[31:2] == 30'd0);
  assign w_pop_req = w_wr_hit & (w_wr_off[1:0] == REG_POP);
  assign w_ctrl_wr = w_wr_hit & (w_wr_off[1:0] == REG_CTRL);
  assign w_clr     = w_ctrl_wr & inputData[CTRL_CLR_ERR];
  // A pop in the same cycle makes room, so only push-without-pop on full overruns.
  assign w_ovr_set = w_push & w_full & ~w_pop_req;

  uart_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop_req),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = (r_cnt != 16'd0) ? r_cnt - 16'd1 : 16'd0;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_push        = 1'b0;
    w_frm_set     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
    w_par_set     = 1'b0;
`endif
    if (!r_rx_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = CNT_HALF;
          end
        end
        S_START: begin
          if (w_expire) begin
            if (!w_rx) begin
              w_state_nxt   = S_DATA;
              w_bit_idx_nxt = 3'd0;
              w_cnt_nxt     = CNT_FULL;
`ifdef UART_RX_PARITY_EN
              w_par_bad_nxt = 1'b0;
`endif
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_expire) begin
            w_shift_nxt = {w_rx, r_shift[7:1]};
            w_cnt_nxt   = CNT_FULL;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_bit_idx_nxt = r_bit_idx + 3'd1;
            end
          end
        end
        S_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (w_expire) begin
            // Even parity: data bits plus parity bit carry an even number of ones.
            if (w_rx != ^r_shift) begin
              w_par_bad_nxt = 1'b1;
              w_par_set     = 1'b1;
            end
            w_state_nxt = S_STOP;
            w_cnt_nxt   = CNT_FULL;
          end
`else
          w_state_nxt = S_IDLE;
`endif
        end
        S_STOP: begin
          if (w_expire) begin
            if (w_rx) begin
`ifdef UART_RX_PARITY_EN
              w_push = ~r_par_bad;
`else
              w_push = 1'b1;
`endif
              w_state_nxt = S_IDLE;
            end else begin
              w_frm_set   = 1'b1;
              w_state_nxt = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (w_rx) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_rx_en   <= 1'b0;
      r_overrun <= 1'b0;
      r_frm_err <= 1'b0;
      r_irq     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
      r_par_err <= 1'b0;
`endif
    end else begin
      r_rx_s1   <= RxD;
      r_rx_s2   <= r_rx_s1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      if (w_ctrl_wr) r_rx_en <= inputData[CTRL_RX_EN];
      // Set terms dominate the clear so a same-cycle error is never lost.
      r_overrun <= w_ovr_set | (r_overrun & ~w_clr);
      r_frm_err <= w_frm_set | (r_frm_err & ~w_clr);
      r_irq     <= r_rx_en & ~w_empty;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_nxt;
      r_par_err <= w_par_set | (r_par_err & ~w_clr);
`endif
    end
  end

  always_comb begin
    w_status                                = 32'd0;
    w_status[ST_NOT_EMPTY]                  = ~w_empty;
    w_status[ST_FULL]                       = w_full;
    w_status[ST_OVERRUN]                    = r_overrun;
    w_status[ST_FRAMING]                    = r_frm_err;
    w_status[ST_COUNT_LSB +: FIFO_AW + 1]   = w_count;
`ifdef UART_RX_PARITY_EN
    w_status[ST_PARITY]                     = r_par_err;
`endif
  end

  assign w_rd_off = outputAddr - BASE_ADDR;

  always_comb begin
    outputData = 32'd0;
    if (w_rd_off[31:2] == 30'd0) begin
      case (w_rd_off[1:0])
        REG_RXDATA: outputData[7:0] = w_empty ? 8'd0 : w_head;
        REG_STATUS: outputData = w_status;
        REG_CTRL:   outputData[CTRL_RX_EN] = r_rx_en;
        default:    outputData = 32'd0;
      endcase
    end
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_uart_rx_mm.sv
// tb/tb_uart_rx_mm.sv - directed self-checking bench for uart_rx_mm
module tb_uart_rx_mm;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int          CBP  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RxD;
  logic [31:0] inputData;
  logic [31:0] inputAddr;
  logic        wrEn;
  logic [31:0] outputAddr;
  logic [31:0] outputData;
  logic        irq;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] d;

  uart_rx_mm #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CBP), .FIFO_AW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .RxD        (RxD),
    .inputData  (inputData),
    .inputAddr  (inputAddr),
    .wrEn       (wrEn),
    .outputAddr (outputAddr),
    .outputData (outputData),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] v);
    outputAddr = BASE + off;
    #1;
    v = outputData;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] v);
    inputAddr = BASE + off;
    inputData = v;
    wrEn      = 1'b1;
    @(posedge clk);
    #1;
    wrEn      = 1'b0;
  endtask

  // One frame, 16 clocks per bit. Cycle c counts edges after the start-bit edge.
  // The receiver samples the stop bit on edge 155; pop_at_stop writes POP in that cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit pop_at_stop,
                            input int abort_at, input int tail_low);
    int slot;
    @(posedge clk);
    #1;
    RxD = 1'b0;
    for (int c = 1; c <= 165 + tail_low; c++) begin
      @(posedge clk);
      #1;
      if (c == abort_at) return;
      slot = c / 16;
      if (slot == 0)      RxD = 1'b0;
      else if (slot <= 8) RxD = b[slot-1];
      else if (slot == 9) RxD = stop_v;
      else                RxD = (c < 160 + tail_low) ? 1'b0 : 1'b1;
      if (pop_at_stop && c == 154) begin
        inputAddr = BASE + 32'd2;
        wrEn      = 1'b1;
      end else if (pop_at_stop && c == 155) begin
        wrEn      = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_reset;
    rst = 1'b0; RxD = 1'b1; wrEn = 1'b0;
    inputData = '0; inputAddr = '0; outputAddr = BASE;
    tick(3);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rd(32'd1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
    rst = 1'b1;
    tick(2);
    rd(32'd3, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    rd(32'd0, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_rxdata got=%h exp=0", d); end
    // Receiver disabled: a full frame must be ignored.
    send(8'h12);
    rd(32'd1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL disabled_status got=%h exp=0", d); end
  endtask

  task automatic test_basic;
    wr(32'd3, 32'd1);
    rd(32'd3, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL basic_ctrl got=%h exp=1", d); end
    send(8'hA5);
    rd(32'd1, d);
    checks++; if (d !== 32'h101) begin failures++; $display("FAIL basic_status got=%h exp=101", d); end
    rd(32'd0, d);
    checks++; if (d !== 32'hA5) begin failures++; $display("FAIL basic_rxdata got=%h exp=a5", d); end
    rd(32'd4, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL basic_above_range got=%h exp=0", d); end
    tick(1);
    rd(32'hFFFF_FFFF, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL basic_below_range got=%h exp=0", d); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL basic_irq_high got=%b exp=1", irq); end
    wr(32'd2, 32'd0);
    rd(32'd1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL basic_status_pop got=%h exp=0", d); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL basic_irq_lag got=%b exp=1", irq); end
    tick(1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL basic_irq_low got=%b exp=0", irq); end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 9; i++) begin
      send(8'(i));
      rd(32'd1, d);
      if (i == 7) begin
        checks++; if (d !== 32'h803) begin failures++; $display("FAIL ovr_full_status got=%h exp=803", d); end
      end else if (i == 8) begin
        checks++; if (d !== 32'h807) begin failures++; $display("FAIL ovr_overrun_status got=%h exp=807", d); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      rd(32'd0, d);
      checks++; if (d !== 32'(i)) begin failures++; $display("FAIL ovr_pop_%0d got=%h exp=%h", i, d, i); end
      wr(32'd2, 32'd0);
    end
    rd(32'd1, d);
    checks++; if (d !== 32'h004) begin failures++; $display("FAIL ovr_sticky got=%h exp=004", d); end
    wr(32'd3, 32'd3);
    rd(32'd1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL ovr_cleared got=%h exp=0", d); end
    rd(32'd3, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL ovr_ctrl_readback got=%h exp=1", d); end
  endtask

  task automatic test_framing;
    send_frame(8'h3C, 1'b0, 1'b0, 0, 100);
    rd(32'd1, d);
    checks++; if (d !== 32'h008) begin failures++; $display("FAIL frm_status got=%h exp=008", d); end
    send(8'h55);
    rd(32'd1, d);
    checks++; if (d !== 32'h109) begin failures++; $display("FAIL frm_next_status got=%h exp=109", d); end
    rd(32'd0, d);
    checks++; if (d !== 32'h55) begin failures++; $display("FAIL frm_next_rxdata got=%h exp=55", d); end
    wr(32'd3, 32'd3);
    rd(32'd1, d);
    checks++; if (d !== 32'h101) begin failures++; $display("FAIL frm_clear got=%h exp=101", d); end
    wr(32'd2, 32'd0);
  endtask

  task automatic test_glitch;
    tick(1);
    RxD = 1'b0;
    tick(4);
    RxD = 1'b1;
    tick(40);
    rd(32'd1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL glitch_status got=%h exp=0", d); end
    send(8'h5A);
    rd(32'd0, d);
    checks++; if (d !== 32'h5A) begin failures++; $display("FAIL glitch_next_rxdata got=%h exp=5a", d); end
    wr(32'd2, 32'd0);
  endtask

  task automatic test_full_pop_push;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    rd(32'd1, d);
    checks++; if (d !== 32'h803) begin failures++; $display("FAIL fpp_prefill got=%h exp=803", d); end
    send_frame(8'h77, 1'b1, 1'b1, 0, 0);
    rd(32'd1, d);
    checks++; if (d !== 32'h803) begin failures++; $display("FAIL fpp_status got=%h exp=803", d); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 32'h11 + 32'(i) : 32'h77;
      rd(32'd0, d);
      checks++; if (d !== exp) begin failures++; $display("FAIL fpp_pop_%0d got=%h exp=%h", i, d, exp); end
      wr(32'd2, 32'd0);
    end
    rd(32'd1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL fpp_drained got=%h exp=0", d); end
  endtask

  task automatic test_async_reset;
    send(8'h99);
    send_frame(8'hF0, 1'b1, 1'b0, 60, 0);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL arst_irq_before got=%b exp=1", irq); end
    rst = 1'b0;
    rd(32'd1, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL arst_status got=%h exp=0", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL arst_irq got=%b exp=0", irq); end
    rd(32'd3, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL arst_ctrl got=%h exp=0", d); end
    RxD = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
    wr(32'd3, 32'd1);
    send(8'hF0);
    rd(32'd1, d);
    checks++; if (d !== 32'h101) begin failures++; $display("FAIL arst_after_status got=%h exp=101", d); end
    rd(32'd0, d);
    checks++; if (d !== 32'hF0) begin failures++; $display("FAIL arst_after_rxdata got=%h exp=f0", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_framing();
    test_glitch();
    test_full_pop_push();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_mm.md
Name: uart_rx_mm

Overview:
Memory-mapped UART receiver that sits on the CPU data bus next to the existing UART and data cache. It is the receiving end of the serial link: it deserialises 8N1 frames from RxD, buffers bytes in a small FIFO, and exposes them through bus registers plus an IRQ line. Its outputData feeds the output data mux; irq feeds one IRQBus bit.

Parameters:
BASE_ADDR, 32'h0000_0400, word address of register 0; the block decodes BASE_ADDR..BASE_ADDR+3.
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); legal range 4..65535.
FIFO_AW, 3, log2 of FIFO depth (default depth 8).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
RxD  input  1  serial input, idle high, asynchronous to clk
inputData  input  32  CPU write data
inputAddr  input  32  CPU write address
wrEn  input  1  CPU write strobe, one cycle per write
outputAddr  input  32  CPU read address
outputData  output  32  read data, combinational from outputAddr; 0 when outputAddr is outside the block
irq  output  1  level IRQ, high while enabled and FIFO not empty

Behaviour:
- Reset (rst=0, async): FSM to IDLE, FIFO empty, sticky flags cleared, CTRL=0, irq=0, synchroniser flops set to 1.
- RxD passes through a 2-flop synchroniser; every internal use of RxD is the synchronised copy.
- Registers (offset from BASE_ADDR):
  - +0 RXDATA (R): {24'b0, FIFO head}; reading does not pop; 0 when empty.
  - +1 STATUS (R): [0] notEmpty, [1] full, [2] overrun, [3] framingErr, [4] parityErr, [11:8] count; all other bits 0.
  - +2 POP (W): any write pops the head; ignored when empty.
  - +3 CTRL (R/W): [0] rxEn, [1] clrErr (write 1 clears bits 2..4, self-clearing, reads 0).
- Receiver FSM (runs only while rxEn=1):
  - IDLE: on a low level, load counter with CLKS_PER_BIT/2 and go to START.
  - START: when the counter expires, re-sample. If still low, go to DATA (bit index 0, counter = CLKS_PER_BIT). If high, treat as a glitch and return to IDLE.
  - DATA: sample at each counter expiry, LSB first; after bit 7, go to STOP (or PARITY, see Optional Feature).
  - STOP: sample at counter expiry. If high, push the byte. If low, set framingErr, discard the byte, and go to BREAK.
  - BREAK: wait for the line to go high, then go to IDLE.
- Bytes are pushed in the cycle of the stop-bit sample; a pushed byte is readable in RXDATA on the next cycle.
- Clearing rxEn mid-frame sends the FSM to IDLE on the next cycle and discards the partial byte; FIFO contents are kept.
- FIFO full + push: byte dropped, overrun set.
- Same-cycle push and pop:
  - Both are performed; count is unchanged.
  - Legal even when full (no overrun).
  - When empty, the pop is ignored and the push proceeds.
- Same-cycle clrErr write and a new error event: the new error wins, so the flag stays set.
- Pointers wrap modulo 2^FIFO_AW. count is FIFO_AW+1 bits wide, zero-extended into [11:8].
- irq = rxEn & notEmpty, registered, so it lags the FIFO state by one cycle.

Optional Feature:
UART_RX_PARITY_EN: when defined, the frame is 8E1. A PARITY state sits between DATA and STOP. On mismatch, parityErr is set and the byte is discarded; the stop bit is still checked. When undefined, there is no PARITY state, and STATUS[4] is tied to 0.

Decomposition:
- Shared package uart_rx_pkg:
  - register offset constants
  - STATUS bit-position constants
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK)
  - CTRL bit positions
- One sub-module, uart_rx_fifo: synchronous FIFO, 8-bit wide, parameterised FIFO_AW, with push/pop/full/empty/count outputs and the same async active-low reset.

Test Plan (CLKS_PER_BIT=16, BASE_ADDR=0x400):
1. CTRL=1, send frame 0xA5 -> STATUS=0x101, RXDATA=0xA5, irq high; write POP -> STATUS=0x000, irq low.
2. Send 9 bytes 0x00..0x08 without popping -> after the 8th byte STATUS[1]=1; after the 9th, overrun=1 and count=8; pops return 0x00..0x07 in order.
3. Send 0x3C with the stop bit driven low -> framingErr=1, count=0; FSM waits in BREAK until the line goes high; a following 0x55 is received correctly; writing CTRL=3 clears framingErr.
4. RxD low pulse of 4 clocks -> no byte, no error, FSM back in IDLE.
5. FIFO full, POP written in the same cycle as the stop-bit sample of 0x77 -> count stays 8, no overrun, tail entry is 0x77.
6. rst pulsed low mid-DATA of 0xF0 -> STATUS=0, irq=0, CTRL=0 immediately (async); after re-enable, 0xF0 sent in full is received.
